// File: rtl/adder_share_arb.sv
// Round-robin controller that time-shares one external adder
// between four requesters and returns captured results.
module adder_share_arb #(
    parameter int W    = 16,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_flat,
    input  logic [NREQ*W-1:0] b_flat,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      res_sum,
    output logic              res_carry,
    output logic [1:0]        res_id,
    output logic              busy,
    output logic [W-1:0]      add_in1,
    output logic [W-1:0]      add_in2,
    input  logic [W-1:0]      add_out,
    input  logic              add_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic [W-1:0] sum_q, sum_d;
    logic       carry_q, carry_d;
    logic [1:0] rid_q, rid_d;

    logic       found;
    logic [1:0] win;
    logic [1:0] cand;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    // Rotating priority search starting at the pointer.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Operand mux for the requester that wins the search.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 2'(i)) begin
                sel_a = a_flat[i*W +: W];
                sel_b = b_flat[i*W +: W];
            end
        end
    end

    // Next-state logic: arbitrate, execute, respond.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        rid_d   = rid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = win;
                    opa_d   = sel_a;
                    opb_d   = sel_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d   = add_out;
                carry_d = add_carry;
                rid_d   = idx_q;
                ptr_d   = idx_q + 2'd1;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            rid_q   <= rid_d;
        end
    end

    // Outputs decoded only from registers, so no path from req.
    always_comb begin
        gnt  = '0;
        done = '0;
        if (state_q == EXEC) gnt[idx_q] = 1'b1;
        if (state_q == RESP) done[idx_q] = 1'b1;
        busy    = (state_q != IDLE);
        add_in1 = busy ? opa_q : '0;
        add_in2 = busy ? opb_q : '0;
    end

    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = rid_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb with an external
// adder model and a round-robin reference model.
module tb_adder_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] a_flat;
    logic [63:0] b_flat;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] res_sum;
    logic        res_carry;
    logic [1:0]  res_id;
    logic        busy;
    logic [15:0] add_in1;
    logic [15:0] add_in2;
    logic [15:0] add_out;
    logic        add_carry;

    logic [15:0] a [4];
    logic [15:0] b [4];

    int n_chk = 0;
    int n_fail = 0;
    int mptr = 0;
    int w;

    always #5 clk = ~clk;

    // The shared adder lives outside the DUT.
    assign {add_carry, add_out} = {1'b0, add_in1} + {1'b0, add_in2};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_flat[i*16 +: 16] = a[i];
            b_flat[i*16 +: 16] = b[i];
        end
    end

    adder_share_arb #(.W(16), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt), .done(done),
        .res_sum(res_sum), .res_carry(res_carry),
        .res_id(res_id), .busy(busy),
        .add_in1(add_in1), .add_in2(add_in2),
        .add_out(add_out), .add_carry(add_carry)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Runs one full operation starting in IDLE, one tick after an edge.
    task automatic serve(input bit chg, output int win);
        logic [16:0] s;
        logic [15:0] ea, eb;
        win = pick(req, mptr);
        ea = a[win];
        eb = b[win];
        s = {1'b0, ea} + {1'b0, eb};
        @(posedge clk); #1;
        chk("exec_gnt", 32'(gnt), 32'(4'b1 << win));
        chk("exec_done", 32'(done), 32'h0);
        chk("exec_busy", 32'(busy), 32'h1);
        chk("exec_in1", 32'(add_in1), 32'(ea));
        chk("exec_in2", 32'(add_in2), 32'(eb));
        if (chg) a[win] = ~a[win];
        @(posedge clk); #1;
        chk("resp_done", 32'(done), 32'(4'b1 << win));
        chk("resp_gnt", 32'(gnt), 32'h0);
        chk("resp_sum", 32'(res_sum), 32'(s[15:0]));
        chk("resp_carry", 32'(res_carry), 32'(s[16]));
        chk("resp_id", 32'(res_id), 32'(win));
        chk("resp_busy", 32'(busy), 32'h1);
        req[win] = 1'b0;
        mptr = (win + 1) % 4;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_in1", 32'(add_in1), 32'h0);
        chk("idle_sum", 32'(res_sum), 32'(s[15:0]));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0;
        for (int i = 0; i < 4; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sum", 32'(res_sum), 32'h0);
        chk("rst_carry", 32'(res_carry), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        chk("rst_in1", 32'(add_in1), 32'h0);
        chk("rst_in2", 32'(add_in2), 32'h0);
        rst = 1'b0;

        // Idle with no request stays idle.
        repeat (2) @(posedge clk);
        #1;
        chk("noreq_busy", 32'(busy), 32'h0);

        // Single request.
        a[0] = 16'h1234;
        b[0] = 16'h1111;
        req = 4'b0001;
        serve(1'b0, w);
        chk("t1_sum", 32'(res_sum), 32'h2345);

        // Overflow cases.
        a[2] = 16'hFFFF;
        b[2] = 16'h0001;
        req = 4'b0100;
        serve(1'b0, w);
        chk("ovf1_carry", 32'(res_carry), 32'h1);
        a[2] = 16'h8000;
        b[2] = 16'h8000;
        req = 4'b0100;
        serve(1'b0, w);
        chk("ovf2_sum", 32'(res_sum), 32'h0);

        // Fairness from a fresh pointer.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 16'(i);
            b[i] = 16'h0100;
        end
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, w);
            chk("rr_order", 32'(w), 32'(k));
            chk("rr_sum", 32'(res_sum), 32'(16'h0100 + 16'(k)));
        end

        // Pointer wrap.
        req = 4'b1000;
        serve(1'b0, w);
        chk("wrap_first", 32'(w), 32'h3);
        req = 4'b1001;
        serve(1'b0, w);
        chk("wrap_zero", 32'(w), 32'h0);
        serve(1'b0, w);
        chk("wrap_three", 32'(w), 32'h3);

        // Reset during EXEC.
        a[1] = 16'h0A0A;
        b[1] = 16'h0505;
        req = 4'b0010;
        @(posedge clk); #1;
        chk("mid_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_done", 32'(done), 32'h0);
        chk("mid_gnt0", 32'(gnt), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_sum", 32'(res_sum), 32'h0);
        chk("mid_in1", 32'(add_in1), 32'h0);
        rst = 1'b0;
        mptr = 0;
        serve(1'b0, w);
        chk("mid_after", 32'(res_sum), 32'h0F0F);

        // Operand change after grant is ignored.
        a[1] = 16'h1000;
        b[1] = 16'h0234;
        req = 4'b0010;
        serve(1'b1, w);
        chk("chg_sum", 32'(res_sum), 32'h1234);

        // Random traffic.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 16'($urandom);
                b[i] = 16'($urandom);
            end
            req = 4'($urandom_range(1, 15));
            serve(1'b0, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
